// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the power-of-two clock divider controller.
// Used by clk_div_core, clk_div_sched and the bench.
package clk_div_pkg;

    localparam int NUM_RATIOS = 5;
    localparam int SEL_W      = 3;
    localparam int CNT_W      = NUM_RATIOS - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Reload value for one half period of ratio sel: 2^sel - 1.
    function automatic logic [CNT_W-1:0] half_period(input logic [SEL_W-1:0] sel);
        logic [CNT_W:0] p;
        p = (CNT_W+1)'(1) << sel;
        return CNT_W'(p - (CNT_W+1)'(1));
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period down-counter producing div_out / div_tick.
// en low parks the divider low after the current high phase completes.
module clk_div_core #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic [CNT_W-1:0] rl_val,
    output logic             bnd,
    output logic             div_out,
    output logic             div_tick
);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] nxt_cnt;

    assign nxt_cnt = ld ? ld_val : rl_val;
    // While parked low, every edge counts as a boundary so pending ratios land.
    assign bnd     = (hcnt == '0) && (div_out || !en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt     <= '0;
            div_out  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            div_tick <= 1'b0;
            if (hcnt != '0) begin
                hcnt <= hcnt - CNT_W'(1);
            end else if (div_out) begin
                div_out <= 1'b0;
                hcnt    <= en ? nxt_cnt : '0;
            end else if (en) begin
                div_out  <= 1'b1;
                div_tick <= 1'b1;
                hcnt     <= nxt_cnt;
            end
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time ratio controller: valid/ready config port, switch at falling boundary.
// Optional CLK_DIV_SCHED_GATE_EN adds the div_en gating input.
module clk_div_sched #(
    parameter int NUM_RATIOS  = clk_div_pkg::NUM_RATIOS,
    parameter int SEL_W       = clk_div_pkg::SEL_W,
    parameter int DEFAULT_SEL = 0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CLK_DIV_SCHED_GATE_EN
    input  logic             div_en,
`endif
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             cfg_done,
    output logic             busy,
    output logic [SEL_W-1:0] act_sel,
    output logic             div_out,
    output logic             div_tick
);

    import clk_div_pkg::*;

    localparam logic [SEL_W:0]   NR   = NUM_RATIOS[SEL_W:0];
    localparam logic [SEL_W-1:0] DSEL = DEFAULT_SEL[SEL_W-1:0];

    state_t           state, nxt_state;
    logic [SEL_W-1:0] pend_sel, nxt_pend, nxt_act;
    logic             nxt_err, nxt_done;
    logic             en, bnd, ld;

`ifdef CLK_DIV_SCHED_GATE_EN
    assign en = div_en;
`else
    assign en = 1'b1;
`endif

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state == ST_PEND);
    assign ld        = busy && bnd;

    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ld       (ld),
        .ld_val   (half_period(pend_sel)),
        .rl_val   (half_period(act_sel)),
        .bnd      (bnd),
        .div_out  (div_out),
        .div_tick (div_tick)
    );

    always_comb begin
        nxt_state = state;
        nxt_pend  = pend_sel;
        nxt_act   = act_sel;
        nxt_err   = 1'b0;
        nxt_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if ({1'b0, cfg_sel} >= NR) begin
                        nxt_err = 1'b1;
                    end else if (cfg_sel == act_sel) begin
                        nxt_done = 1'b1;
                    end else begin
                        nxt_pend  = cfg_sel;
                        nxt_state = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (bnd) begin
                    nxt_act   = pend_sel;
                    nxt_done  = 1'b1;
                    nxt_state = ST_IDLE;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            pend_sel <= DSEL;
            act_sel  <= DSEL;
            cfg_err  <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            state    <= nxt_state;
            pend_sel <= nxt_pend;
            act_sel  <= nxt_act;
            cfg_err  <= nxt_err;
            cfg_done <= nxt_done;
        end
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: vector table plus hand sequences.
// Define CLK_DIV_SCHED_GATE_EN to also exercise div_en.
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       div_en;
    logic       cfg_valid;
    logic [2:0] cfg_sel;
    logic       cfg_ready, cfg_err, cfg_done, busy;
    logic [2:0] act_sel;
    logic       div_out, div_tick;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clk_div_sched dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CLK_DIV_SCHED_GATE_EN
        .div_en    (div_en),
`endif
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cfg_done  (cfg_done),
        .busy      (busy),
        .act_sel   (act_sel),
        .div_out   (div_out),
        .div_tick  (div_tick)
    );

    typedef struct {
        int n, v, sel;
        int dout, tick, rdy, bsy, done, err, act;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int d, input int t,
                           input int r, input int b, input int dn,
                           input int e, input int a);
        chk({tag, ".div_out"},   int'(div_out),   d);
        chk({tag, ".div_tick"},  int'(div_tick),  t);
        chk({tag, ".cfg_ready"}, int'(cfg_ready), r);
        chk({tag, ".busy"},      int'(busy),      b);
        chk({tag, ".cfg_done"},  int'(cfg_done),  dn);
        chk({tag, ".cfg_err"},   int'(cfg_err),   e);
        chk({tag, ".act_sel"},   int'(act_sel),   a);
    endtask

    // Drive for one edge, return at the following falling edge.
    task automatic step(input int v, input int s);
        logic [31:0] sv;
        sv = s;
        cfg_valid = (v != 0);
        cfg_sel   = sv[2:0];
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!cfg_done && k < 64) begin
            step(0, 0);
            k++;
        end
        chk(nm, int'(cfg_done), 1);
    endtask

    initial begin
        int lo, hi, k;
        tbl = '{
            '{1, 0, 0, 1, 1, 1, 0, 0, 0, 0},
            '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0},
            '{1, 0, 0, 1, 1, 1, 0, 0, 0, 0},
            '{1, 1, 3, 0, 0, 0, 1, 0, 0, 0},
            '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0},
            '{1, 0, 0, 0, 0, 1, 0, 1, 0, 3},
            '{7, 0, 0, 0, 0, 1, 0, 0, 0, 3},
            '{1, 0, 0, 1, 1, 1, 0, 0, 0, 3},
            '{1, 1, 6, 1, 0, 1, 0, 0, 1, 3},
            '{6, 0, 0, 1, 0, 1, 0, 0, 0, 3},
            '{8, 0, 0, 0, 0, 1, 0, 0, 0, 3},
            '{1, 0, 0, 1, 1, 1, 0, 0, 0, 3},
            '{1, 1, 3, 1, 0, 1, 0, 1, 0, 3},
            '{6, 0, 0, 1, 0, 1, 0, 0, 0, 3},
            '{1, 0, 0, 0, 0, 1, 0, 0, 0, 3}
        };

        reset = 1'b1;
        div_en = 1'b1;
        cfg_valid = 1'b0;
        cfg_sel = 3'd0;
        repeat (5) @(negedge clk);
        chk_all("reset", 0, 0, 1, 0, 0, 0, 0);
        reset = 1'b0;

        // /2 free-run, /2->/16 accepted on a boundary, bad select, same select
        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(tbl[i].v, tbl[i].sel);
                chk_all($sformatf("row%0d.%0d", i, j), tbl[i].dout,
                        tbl[i].tick, tbl[i].rdy, tbl[i].bsy,
                        tbl[i].done, tbl[i].err, tbl[i].act);
            end
        end

        // /16 -> /32, then /32 -> /2 requested mid-high
        step(1, 4);
        chk("s4.busy", int'(busy), 1);
        wait_done("s4.done32");
        chk("s4.act32", int'(act_sel), 4);
        lo = 1;
        k = 0;
        while (k < 100) begin
            step(0, 0);
            k++;
            if (div_out) break;
            lo++;
        end
        chk("s4.low32", lo, 16);
        hi = 1;
        k = 0;
        while (k < 100) begin
            step(hi == 5 ? 1 : 0, 0);
            k++;
            if (!div_out) break;
            hi++;
        end
        chk("s4.high32", hi, 16);
        chk("s4.done2", int'(cfg_done), 1);
        chk("s4.act2", int'(act_sel), 0);
        step(0, 0);
        chk("s4.lowlen1", int'(div_out), 1);
        chk("s4.tick", int'(div_tick), 1);
        step(0, 0);
        chk("s4.high1", int'(div_out), 0);

        // /2 -> /4, then /4 -> /8 accepted on the exact boundary edge
        step(1, 1);
        chk("s5.busy1", int'(busy), 1);
        step(0, 0);
        chk_all("s5.sw4", 0, 0, 1, 0, 1, 0, 1);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("s5.prehigh", int'(div_out), 1);
        step(1, 2);
        chk_all("s5.acc", 0, 0, 0, 1, 0, 0, 1);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk_all("s5.wait", 1, 0, 0, 1, 0, 0, 1);
        step(0, 0);
        chk_all("s5.sw8", 0, 0, 1, 0, 1, 0, 2);

        // reset while busy
        step(1, 4);
        chk("s6.busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1 chk_all("s6.async", 0, 0, 1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(0, 0);
        chk_all("s6.rel", 1, 1, 1, 0, 0, 0, 0);

`ifdef CLK_DIV_SCHED_GATE_EN
        step(1, 2);
        wait_done("g.done8");
        k = 0;
        while (!div_out && k < 20) begin
            step(0, 0);
            k++;
        end
        div_en = 1'b0;
        hi = 1;
        k = 0;
        while (k < 20) begin
            step(0, 0);
            k++;
            if (!div_out) break;
            hi++;
        end
        chk("g.high", hi, 4);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            chk($sformatf("g.hold%0d", i), int'(div_out), 0);
        end
        div_en = 1'b1;
        step(0, 0);
        chk("g.restart", int'(div_out), 1);
        chk("g.tick", int'(div_tick), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
